main_cu_fsm: RTL

Multicycle main control unit for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and mux selects. It also produces the 2-bit `alu_op` that feeds the ALU control decoder directly downstream. Memory accesses wait on a ready handshake, and unsupported opcodes are flagged and skipped.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/main_cu_fsm_if.sv | 30 +++
 rtl/main_cu_decode.sv | 99 +++++++++
 rtl/main_cu_fsm.sv | 68 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode, alu_op and control-state encodings shared by the MIPS control path
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        R_EX    = 4'd6,
        R_WB    = 4'd7,
        BEQ_EX  = 4'd8,
        ADDI_EX = 4'd9,
        ADDI_WB = 4'd10,
        J_EX    = 4'd11
    } state_t;
    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction
endpackage

// File: rtl/main_cu_fsm_if.sv
// main_cu_fsm_if: control-unit to datapath bundle; master is the control unit, slave the datapath
interface main_cu_fsm_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, ir_write, mem_read, mem_write, reg_write, iord, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal, state
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, ir_write, mem_read, mem_write, reg_write, iord, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal, state
    );
endinterface

// File: rtl/main_cu_decode.sv
// main_cu_decode: maps control state plus mem_ready/zero to datapath enables and selects
module main_cu_decode
    import mips_pkg::*;
(
    input  logic       i_rst_n,
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_zero,
    output logic       o_pc_en,
    output logic       o_ir_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_iord,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_src,
    output logic [1:0] o_alu_op,
    output logic       o_illegal
);
    logic w_pc_write, w_branch, w_ir_write, w_mem_read, w_mem_write, w_reg_write, w_illegal;

    // Selects default to their FETCH values so reset and unused states look like FETCH
    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        o_iord       = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b01;
        o_pc_src     = 2'b00;
        o_alu_op     = ALUOP_ADD;
        case (i_state)
            FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = i_mem_ready;
                w_pc_write = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_b = 2'b11;
                w_illegal   = !op_legal(i_opcode);
            end
            MEM_ADR, ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            MEM_RD: begin
                w_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            MEM_WB: begin
                w_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                o_iord      = 1'b1;
                w_mem_write = i_mem_ready;
            end
            R_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b00;
                o_alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                w_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            BEQ_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b00;
                o_alu_op    = ALUOP_SUB;
                o_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            ADDI_WB: w_reg_write = 1'b1;
            J_EX: begin
                o_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_pc_en     = i_rst_n & (w_pc_write | (w_branch & i_zero));
    assign o_ir_write  = i_rst_n & w_ir_write;
    assign o_mem_read  = i_rst_n & w_mem_read;
    assign o_mem_write = i_rst_n & w_mem_write;
    assign o_reg_write = i_rst_n & w_reg_write;
    assign o_illegal   = i_rst_n & w_illegal;
endmodule

// File: rtl/main_cu_fsm.sv
// main_cu_fsm: multicycle MIPS main control unit; state and latched opcode registers plus next-state logic
module main_cu_fsm
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    main_cu_fsm_if.master bus
);
    state_t     r_state, w_next;
    logic [5:0] r_opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) r_opcode <= bus.opcode;
        end
    end

    // MEM_ADR steers on the latched opcode; the IR may already be changing by then
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     w_next = R_EX;
                    OP_LW, OP_SW: w_next = MEM_ADR;
                    OP_BEQ:       w_next = BEQ_EX;
                    OP_ADDI:      w_next = ADDI_EX;
                    OP_J:         w_next = J_EX;
                    default:      w_next = FETCH;
                endcase
            end
            MEM_ADR: w_next = (r_opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  w_next = bus.mem_ready ? MEM_WB : MEM_RD;
            MEM_WR:  w_next = bus.mem_ready ? FETCH : MEM_WR;
            R_EX:    w_next = R_WB;
            ADDI_EX: w_next = ADDI_WB;
            default: w_next = FETCH;
        endcase
    end

    assign bus.state = r_state;

    main_cu_decode u_decode (
        .i_rst_n      (rst_n),
        .i_state      (r_state),
        .i_opcode     (bus.opcode),
        .i_mem_ready  (bus.mem_ready),
        .i_zero       (bus.zero),
        .o_pc_en      (bus.pc_en),
        .o_ir_write   (bus.ir_write),
        .o_mem_read   (bus.mem_read),
        .o_mem_write  (bus.mem_write),
        .o_reg_write  (bus.reg_write),
        .o_iord       (bus.iord),
        .o_reg_dst    (bus.reg_dst),
        .o_mem_to_reg (bus.mem_to_reg),
        .o_alu_src_a  (bus.alu_src_a),
        .o_alu_src_b  (bus.alu_src_b),
        .o_pc_src     (bus.pc_src),
        .o_alu_op     (bus.alu_op),
        .o_illegal    (bus.illegal)
    );
endmodule
